// File: rtl/xeng_tap_gapped.sv
// X-engine baseline tap: gapped input, run-time tap separation, sync
// realignment and accumulation-chain collision detection.
module xeng_tap_gapped #(
   parameter int BITWIDTH            = 4,
   parameter int N_POLS              = 2,
   parameter int P_FACTOR_BITS       = 0,
   parameter int SERIAL_ACC_LEN_BITS = 7,
   parameter int N_ANTS              = 8,
   parameter int SEP_BITS            = 3,
   localparam int P         = 1 << P_FACTOR_BITS,
   localparam int N_STOKES  = N_POLS * N_POLS,
   localparam int IW        = 2 * BITWIDTH * N_POLS * P,
   localparam int AW        = 2 * BITWIDTH + 1 + P_FACTOR_BITS
                              + SERIAL_ACC_LEN_BITS,
   localparam int ACC_WIDTH = N_STOKES * 2 * AW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic                 sync_in,
   input  logic [SEP_BITS-1:0]  tap_sep,
   input  logic [IW-1:0]        a_del,
   input  logic [IW-1:0]        a_ndel,
   input  logic [IW-1:0]        a_end,
   input  logic [ACC_WIDTH-1:0] acc_in,
   input  logic                 valid_in,
   output logic                 valid_fwd,
   output logic                 sync_out,
   output logic [IW-1:0]        a_ndel_out,
   output logic [IW-1:0]        a_end_out,
   output logic [IW-1:0]        a_del_out,
   output logic [ACC_WIDTH-1:0] acc_out,
   output logic                 valid_out,
   output logic                 collision
);

   localparam int L     = 1 << SERIAL_ACC_LEN_BITS;
   localparam int FRAME = N_ANTS * L;
   localparam int CW    = $clog2(FRAME) + 1;
   localparam int KW    = (SERIAL_ACC_LEN_BITS > 0) ? SERIAL_ACC_LEN_BITS : 1;
   localparam int PW    = 2 * BITWIDTH + 1;

   logic [IW-1:0]        dl [L];
   logic [CW-1:0]        sample_ctr;
   logic [CW-1:0]        sc_eff;
   logic [SEP_BITS-1:0]  sep_lat;
   logic [SEP_BITS-1:0]  sep_eff;
   logic                 sync_now;
   logic                 use_end;

   logic [IW-1:0]        a1_q;
   logic [IW-1:0]        b1_q;
   logic                 v1_q;
   logic                 v2_q;
   logic                 v3_q;

   logic signed [PW-1:0] pre_d [N_STOKES][P];
   logic signed [PW-1:0] pim_d [N_STOKES][P];
   logic signed [PW-1:0] pre_q [N_STOKES][P];
   logic signed [PW-1:0] pim_q [N_STOKES][P];
   logic signed [AW-1:0] sre_d [N_STOKES];
   logic signed [AW-1:0] sim_d [N_STOKES];
   logic signed [AW-1:0] sre_q [N_STOKES];
   logic signed [AW-1:0] sim_q [N_STOKES];
   logic signed [AW-1:0] are_q [N_STOKES];
   logic signed [AW-1:0] aim_q [N_STOKES];
   logic signed [AW-1:0] nre   [N_STOKES];
   logic signed [AW-1:0] nim   [N_STOKES];

   logic [KW-1:0]        acc_ctr;
   logic [ACC_WIDTH-1:0] dump_d;
   logic [ACC_WIDTH-1:0] dump_q;
   logic                 dump_v_q;

   // one signed re (im=0) or im (im=1) part of a lane, widened to PW
   function automatic logic signed [PW-1:0] part(
      input logic [IW-1:0] w,
      input int            pol,
      input int            lane,
      input logic          im
   );
      int base;
      base = (N_POLS - 1 - pol) * P * 2 * BITWIDTH
             + lane * 2 * BITWIDTH + (im ? 0 : BITWIDTH);
      return PW'($signed(w[base +: BITWIDTH]));
   endfunction

   // a sync sample becomes sample 0 of a new frame and re-latches tap_sep
   always_comb begin
      sync_now = in_valid & sync_in;
      sc_eff   = sync_now ? '0 : sample_ctr;
      sep_eff  = (in_valid && sc_eff == '0) ? tap_sep : sep_lat;
      use_end  = 32'(sc_eff) < (32'(sep_eff) << SERIAL_ACC_LEN_BITS);
   end

   // frame position and latched separation advance only on valid samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_ctr <= '0;
         sep_lat    <= '0;
      end else if (in_valid) begin
         sample_ctr <= (sc_eff == CW'(FRAME - 1)) ? '0 : sc_eff + CW'(1);
         if (sc_eff == '0)
            sep_lat <= tap_sep;
      end
   end

   // L-deep delay line that ages only on valid samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < L; k++)
            dl[k] <= '0;
      end else if (in_valid) begin
         dl[0] <= a_del;
         for (int k = 1; k < L; k++)
            dl[k] <= dl[k-1];
      end
   end

   // one-cycle passthroughs to the next tap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_fwd  <= 1'b0;
         sync_out   <= 1'b0;
         a_ndel_out <= '0;
         a_end_out  <= '0;
         a_del_out  <= '0;
      end else begin
         valid_fwd  <= in_valid;
         sync_out   <= sync_in;
         a_ndel_out <= a_ndel;
         a_end_out  <= a_end;
         a_del_out  <= dl[L-1];
      end
   end

   // stage 1: operand select
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a1_q <= '0;
         b1_q <= '0;
         v1_q <= 1'b0;
      end else begin
         a1_q <= dl[L-1];
         b1_q <= use_end ? a_end : a_ndel;
         v1_q <= in_valid;
      end
   end

   // a*conj(b) per lane and pol pair
   always_comb begin
      for (int i = 0; i < N_POLS; i++) begin
         for (int j = 0; j < N_POLS; j++) begin
            for (int p = 0; p < P; p++) begin
               pre_d[i*N_POLS+j][p] =
                  part(a1_q, i, p, 1'b0) * part(b1_q, j, p, 1'b0) +
                  part(a1_q, i, p, 1'b1) * part(b1_q, j, p, 1'b1);
               pim_d[i*N_POLS+j][p] =
                  part(a1_q, i, p, 1'b1) * part(b1_q, j, p, 1'b0) -
                  part(a1_q, i, p, 1'b0) * part(b1_q, j, p, 1'b1);
            end
         end
      end
   end

   // stage 2: products; a sync kills whatever is in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '{default: '0};
         pim_q <= '{default: '0};
         v2_q  <= 1'b0;
      end else begin
         pre_q <= pre_d;
         pim_q <= pim_d;
         v2_q  <= v1_q & ~sync_now;
      end
   end

   // sum lanes at accumulator width
   always_comb begin
      for (int k = 0; k < N_STOKES; k++) begin
         sre_d[k] = '0;
         sim_d[k] = '0;
         for (int p = 0; p < P; p++) begin
            sre_d[k] = sre_d[k] + AW'(pre_q[k][p]);
            sim_d[k] = sim_d[k] + AW'(pim_q[k][p]);
         end
      end
   end

   // stage 3: lane sums
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sre_q <= '{default: '0};
         sim_q <= '{default: '0};
         v3_q  <= 1'b0;
      end else begin
         sre_q <= sre_d;
         sim_q <= sim_d;
         v3_q  <= v2_q & ~sync_now;
      end
   end

   // next accumulator value, packed xx first with re above im
   always_comb begin
      dump_d = '0;
      for (int k = 0; k < N_STOKES; k++) begin
         nre[k] = are_q[k] + sre_q[k];
         nim[k] = aim_q[k] + sim_q[k];
         dump_d[(N_STOKES-1-k)*2*AW + AW +: AW] = nre[k];
         dump_d[(N_STOKES-1-k)*2*AW +: AW]      = nim[k];
      end
   end

   // accumulate L products, then hand the sum to the dump register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         are_q    <= '{default: '0};
         aim_q    <= '{default: '0};
         acc_ctr  <= '0;
         dump_q   <= '0;
         dump_v_q <= 1'b0;
      end else if (sync_now) begin
         are_q    <= '{default: '0};
         aim_q    <= '{default: '0};
         acc_ctr  <= '0;
         dump_v_q <= 1'b0;
      end else if (v3_q) begin
         if (acc_ctr == KW'(L - 1)) begin
            dump_q   <= dump_d;
            dump_v_q <= 1'b1;
            are_q    <= '{default: '0};
            aim_q    <= '{default: '0};
            acc_ctr  <= '0;
         end else begin
            are_q    <= nre;
            aim_q    <= nim;
            acc_ctr  <= acc_ctr + KW'(1);
            dump_v_q <= 1'b0;
         end
      end else begin
         dump_v_q <= 1'b0;
      end
   end

   // chain: local dump wins over acc_in, a clash is remembered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_out   <= '0;
         valid_out <= 1'b0;
         collision <= 1'b0;
      end else begin
         acc_out   <= dump_v_q ? dump_q : acc_in;
         valid_out <= dump_v_q | valid_in;
         if (dump_v_q & valid_in)
            collision <= 1'b1;
      end
   end

endmodule
